// File: rtl/uart_axi_buffer.sv
// AXI4-Lite slave placing UART RX/TX byte FIFOs and status/control registers on the
// memory stage's UART bus. Byte loads pop RX, byte stores push TX.
module uart_axi_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] A_RXD  = 2'd0;
    localparam logic [1:0] A_TXD  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Handshake rule: a beat transfers on a rising edge where valid && ready are both
    // high; valid is never withdrawn until that edge, ready may be low at any time.

    logic                  up;
    logic                  aw_held, w_held;
    logic [1:0]            aw_sel_q;
    logic [7:0]            w_byte_q;
    logic                  w_strb_q;
    logic                  overrun;
    logic [DEPTH_LOG2:0]   rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];

    logic                  unused_ok;
    assign unused_ok = ^{axi_arprot, axi_awprot, axi_araddr[31:4], axi_araddr[1:0],
                         axi_awaddr[31:4], axi_awaddr[1:0], axi_wdata[31:8], axi_wstrb[3:1]};

    logic       ar_fire, aw_fire, w_fire, wr_exec;
    logic [1:0] ar_sel, wr_sel;
    logic [7:0] wr_byte;
    logic       wr_strb;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, rx_drop, rx_flush, stat_rd;
    logic       tx_push, tx_pop, tx_flush;

    assign axi_arready = up && !axi_rvalid;
    assign axi_awready = up && !aw_held && !axi_bvalid;
    assign axi_wready  = up && !w_held && !axi_bvalid;

    assign ar_fire = axi_arvalid && axi_arready;
    assign aw_fire = axi_awvalid && axi_awready;
    assign w_fire  = axi_wvalid && axi_wready;
    assign ar_sel  = axi_araddr[3:2];

    // A beat arriving this cycle is used directly, so AW+W together execute at once.
    assign wr_sel  = aw_held ? aw_sel_q : axi_awaddr[3:2];
    assign wr_byte = w_held ? w_byte_q : axi_wdata[7:0];
    assign wr_strb = w_held ? w_strb_q : axi_wstrb[0];
    assign wr_exec = (aw_held || aw_fire) && (w_held || w_fire) && !axi_bvalid;

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[DEPTH_LOG2] != rx_rptr[DEPTH_LOG2]) &&
                      (rx_wptr[DEPTH_LOG2-1:0] == rx_rptr[DEPTH_LOG2-1:0]);
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[DEPTH_LOG2] != tx_rptr[DEPTH_LOG2]) &&
                      (tx_wptr[DEPTH_LOG2-1:0] == tx_rptr[DEPTH_LOG2-1:0]);

    assign rx_pop   = ar_fire && (ar_sel == A_RXD) && !rx_empty;
    assign stat_rd  = ar_fire && (ar_sel == A_STAT);
    assign rx_flush = wr_exec && (wr_sel == A_CTRL) && wr_byte[1];
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign rx_drop  = rx_valid && rx_full && !rx_pop;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rptr[DEPTH_LOG2-1:0]];
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_flush = wr_exec && (wr_sel == A_CTRL) && wr_byte[0];
    assign tx_push  = wr_exec && (wr_sel == A_TXD) && wr_strb && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush) rx_mem[rx_wptr[DEPTH_LOG2-1:0]] <= rx_data;
        if (tx_push && !tx_flush) tx_mem[tx_wptr[DEPTH_LOG2-1:0]] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            up         <= 1'b0;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= OKAY;
            axi_bvalid <= 1'b0;
            axi_bresp  <= OKAY;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_sel_q   <= '0;
            w_byte_q   <= '0;
            w_strb_q   <= 1'b0;
            overrun    <= 1'b0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            tx_wptr    <= '0;
            tx_rptr    <= '0;
        end else begin
            up <= 1'b1;

            if (ar_fire) begin
                axi_rvalid <= 1'b1;
                case (ar_sel)
                    A_RXD: begin
                        axi_rdata <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr[DEPTH_LOG2-1:0]]};
                        axi_rresp <= OKAY;
                    end
                    A_STAT: begin
                        axi_rdata <= {27'd0, overrun, tx_full, tx_empty, rx_full, !rx_empty};
                        axi_rresp <= OKAY;
                    end
                    default: begin
                        axi_rdata <= 32'd0;
                        axi_rresp <= SLVERR;
                    end
                endcase
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end

            if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_sel_q <= axi_awaddr[3:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_byte_q <= axi_wdata[7:0];
                    w_strb_q <= axi_wstrb[0];
                end
                if (wr_exec) begin
                    axi_bvalid <= 1'b1;
                    axi_bresp  <= (wr_sel == A_TXD || wr_sel == A_CTRL) ? OKAY : SLVERR;
                end
            end

            // Flush beats any same-cycle push/pop; a fresh drop beats a STAT-read clear.
            if (rx_flush) begin
                rx_wptr <= '0;
                rx_rptr <= '0;
                overrun <= 1'b0;
            end else begin
                if (rx_push) rx_wptr <= rx_wptr + 1'b1;
                if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
                if (rx_drop)      overrun <= 1'b1;
                else if (stat_rd) overrun <= 1'b0;
            end

            if (tx_flush) begin
                tx_wptr <= '0;
                tx_rptr <= '0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + 1'b1;
                if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_axi_buffer.sv
// Directed + randomized bench for uart_axi_buffer; expectations come from queue-based
// models of the two FIFOs and the overrun flag.
module tb_uart_axi_buffer;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic       m_ovr;

    uart_axi_buffer #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rstn(rstn),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp();
        return {27'd0, m_ovr, tx_exp_q.size() == 16, tx_exp_q.size() == 0,
                rx_exp_q.size() == 16, rx_exp_q.size() != 0};
    endfunction

    task automatic m_rx_push(input logic [7:0] b);
        if (rx_exp_q.size() < 16) rx_exp_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    // Drivers
    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        m_rx_push(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, input int hold, input bit with_rx,
                            input logic [7:0] rxb, output logic [31:0] rd);
        logic [31:0] ed;
        logic [1:0]  er;
        int n;
        @(negedge clk);
        axi_araddr  = {28'h7F00000, a};
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait", 32'(n < 50), 32'd1);
        case (a[3:2])
            2'd0: begin
                ed = (rx_exp_q.size() > 0) ? 32'(rx_exp_q.pop_front()) : 32'd0;
                er = 2'b00;
            end
            2'd2: begin
                ed = stat_exp();
                m_ovr = 1'b0;
                er = 2'b00;
            end
            default: begin
                ed = 32'd0;
                er = 2'b10;
            end
        endcase
        if (with_rx) begin
            rx_valid = 1'b1;
            rx_data  = rxb;
            m_rx_push(rxb);
        end
        @(negedge clk);
        axi_arvalid = 1'b0;
        rx_valid    = 1'b0;
        chk("rvalid_latency", 32'(axi_rvalid), 32'd1);
        chk("rdata", axi_rdata, ed);
        chk("rresp", 32'(axi_rresp), 32'(er));
        rd = axi_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(axi_rvalid), 32'd1);
            chk("rdata_hold", axi_rdata, ed);
            chk("arready_busy", 32'(axi_arready), 32'd0);
        end
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        chk("rvalid_drop", 32'(axi_rvalid), 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input bit finish_b);
        bit aw_done, w_done;
        logic [1:0] eb;
        int c;
        aw_done = 0;
        w_done  = 0;
        c = 0;
        axi_awaddr = {28'h7F00000, a};
        axi_wdata  = d;
        axi_wstrb  = s;
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge clk);
            if (lead > 0 && c == lead) chk("b_before_aw", 32'(axi_bvalid), 32'd0);
            axi_awvalid = !aw_done && (c >= lead);
            axi_wvalid  = !w_done;
            if (axi_awvalid && axi_awready) aw_done = 1;
            if (axi_wvalid && axi_wready) w_done = 1;
            c++;
        end
        chk("aw_w_wait", 32'(aw_done && w_done), 32'd1);
        case (a[3:2])
            2'd1: begin
                if (s[0] && tx_exp_q.size() < 16) tx_exp_q.push_back(d[7:0]);
                eb = 2'b00;
            end
            2'd3: begin
                if (d[0]) tx_exp_q.delete();
                if (d[1]) begin
                    rx_exp_q.delete();
                    m_ovr = 1'b0;
                end
                eb = 2'b00;
            end
            default: eb = 2'b10;
        endcase
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("bvalid_latency", 32'(axi_bvalid), 32'd1);
        chk("bresp", 32'(axi_bresp), 32'(eb));
        if (finish_b) begin
            axi_bready = 1'b1;
            @(negedge clk);
            axi_bready = 1'b0;
            chk("bvalid_drop", 32'(axi_bvalid), 32'd0);
        end
    endtask

    task automatic tx_drain(input int n);
        for (int i = 0; i < n; i++) begin
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk("tx_data", 32'(tx_data), 32'(tx_exp_q[0]));
            tx_ready = 1'b1;
            @(negedge clk);
            void'(tx_exp_q.pop_front());
        end
        tx_ready = 1'b0;
        chk("tx_valid_after", 32'(tx_valid), 32'(tx_exp_q.size() != 0));
    endtask

    // Directed sequence followed by random traffic
    initial begin
        logic [31:0] rd;
        rstn = 1'b0;
        axi_araddr = '0; axi_arvalid = 0; axi_arprot = '0; axi_rready = 0;
        axi_awaddr = '0; axi_awvalid = 0; axi_awprot = '0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0; axi_bready = 0;
        rx_data = '0; rx_valid = 0; tx_ready = 0;
        m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        chk("rst_awready", 32'(axi_awready), 32'd0);
        chk("rst_wready", 32'(axi_wready), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("up_arready", 32'(axi_arready), 32'd1);
        chk("up_awready", 32'(axi_awready), 32'd1);
        chk("up_wready", 32'(axi_wready), 32'd1);

        axi_read(4'h8, 0, 0, 8'h0, rd);
        chk("stat_after_reset", rd, 32'h0000_0004);
        axi_read(4'h0, 0, 0, 8'h0, rd);
        chk("rxd_empty", rd, 32'd0);

        rx_pulse(8'h41);
        rx_pulse(8'h42);
        axi_read(4'h0, 3, 0, 8'h0, rd);
        chk("rxd_first", rd, 32'h41);
        axi_read(4'h0, 0, 0, 8'h0, rd);
        chk("rxd_second", rd, 32'h42);
        axi_read(4'h0, 0, 0, 8'h0, rd);

        axi_write(4'h4, 32'h55, 4'h1, 0, 1);
        chk("tx_valid_55", 32'(tx_valid), 32'd1);
        chk("tx_data_55", 32'(tx_data), 32'h55);
        axi_write(4'h4, 32'h66, 4'h1, 2, 1);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        tx_drain(2);

        for (int i = 0; i <= 16; i++) rx_pulse(8'(i));
        axi_read(4'h8, 0, 0, 8'h0, rd);
        chk("stat_overrun", rd & 32'h13, 32'h13);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        for (int i = 0; i < 16; i++) axi_read(4'h0, 0, 0, 8'h0, rd);

        for (int i = 0; i < 16; i++) rx_pulse(8'(8'h80 + i));
        axi_read(4'h0, 0, 1, 8'hAA, rd);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        chk("full_push_pop_stat", rd & 32'h13, 32'h03);
        axi_write(4'hC, 32'h3, 4'h1, 0, 1);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        chk("stat_after_flush", rd, 32'h4);

        axi_read(4'h4, 0, 0, 8'h0, rd);
        axi_write(4'h8, 32'hFF, 4'hF, 0, 1);
        axi_write(4'h0, 32'h3, 4'hF, 1, 1);
        axi_write(4'h4, 32'h12, 4'h0, 0, 1);
        axi_read(4'h8, 0, 0, 8'h0, rd);

        for (int i = 0; i < 17; i++) axi_write(4'h4, 32'(8'hC0 + i), 4'h1, i % 3, 1);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        tx_drain(16);

        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: rx_pulse(8'($urandom));
                3, 4: axi_read({2'd0, 2'($urandom)}, $urandom_range(0, 2), 1'($urandom), 8'($urandom), rd);
                5: axi_read({2'd2, 2'($urandom)}, 0, 1'($urandom), 8'($urandom), rd);
                6: axi_read({2'($urandom), 2'($urandom)}, 0, 0, 8'h0, rd);
                7: axi_write({2'd1, 2'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 2), 1);
                8: if ($urandom_range(0, 5) == 0)
                       axi_write({2'($urandom), 2'($urandom)}, $urandom, 4'($urandom), 0, 1);
                   else
                       axi_write(4'h4, $urandom, 4'h1, 0, 1);
                default: if (tx_exp_q.size() > 0) tx_drain($urandom_range(1, tx_exp_q.size()));
            endcase
        end

        rx_pulse(8'h5A);
        axi_write(4'h4, 32'h77, 4'h1, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        rstn = 1'b1;
        rx_exp_q.delete();
        tx_exp_q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        axi_read(4'h8, 0, 0, 8'h0, rd);
        chk("stat_after_mid_reset", rd, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
